raizing_gp9001_bus: RTL and testbench

CPU-side initiator for the GP9001 register/VRAM port of `raizing_video`. It turns 68000 bus cycles on the GP9001 and object-bank windows into single GP9001 operations (`GP9001_OP_*` with `GP9001CS`) and waits for `GP9001ACK`. It then returns read data and `CPU_DTACK_N` to the CPU. It sits between the main-CPU address decoder and `raizing_video`, and serves VDP status reads locally from the sync outputs.

---
 rtl/raizing_gp9001_bus_if.sv | 51 +++++
 rtl/raizing_gp9001_bus.sv | 141 ++++++++++++++
 tb/tb_raizing_gp9001_bus.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/raizing_gp9001_bus_if.sv
// ============================================================================
// raizing_gp9001_bus_if : CPU-side and GP9001-side signals of the GP9001 bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface raizing_gp9001_bus_if;
    logic        CPU_CS;
    logic        CPU_OBJ_CS;
    logic [2:0]  CPU_ADDR;
    logic        CPU_RNW;
    logic [15:0] CPU_DIN;
    logic [15:0] CPU_DOUT;
    logic        CPU_DTACK_N;
    logic        GP9001CS;
    logic        GP9001ACK;
    logic [15:0] GP9001DIN;
    logic [15:0] GP9001DOUT;
    logic        GP9001_OP_SELECT_REG;
    logic        GP9001_OP_WRITE_REG;
    logic        GP9001_OP_WRITE_RAM;
    logic        GP9001_OP_READ_RAM_H;
    logic        GP9001_OP_READ_RAM_L;
    logic        GP9001_OP_SET_RAM_PTR;
    logic        GP9001_OP_OBJECTBANK_WR;
    logic [2:0]  GP9001_OBJECTBANK_SLOT;
    logic        CPU_HSYNC;
    logic        CPU_VSYNC;
    logic        CPU_FBLANK;
    logic        TIMEOUT;

    modport slave (
        input  CPU_CS, CPU_OBJ_CS, CPU_ADDR, CPU_RNW, CPU_DIN,
        input  GP9001ACK, GP9001DOUT, CPU_HSYNC, CPU_VSYNC, CPU_FBLANK,
        output CPU_DOUT, CPU_DTACK_N, GP9001CS, GP9001DIN,
        output GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM,
        output GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR,
        output GP9001_OP_OBJECTBANK_WR, GP9001_OBJECTBANK_SLOT, TIMEOUT
    );

    modport master (
        output CPU_CS, CPU_OBJ_CS, CPU_ADDR, CPU_RNW, CPU_DIN,
        output GP9001ACK, GP9001DOUT, CPU_HSYNC, CPU_VSYNC, CPU_FBLANK,
        input  CPU_DOUT, CPU_DTACK_N, GP9001CS, GP9001DIN,
        input  GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM,
        input  GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR,
        input  GP9001_OP_OBJECTBANK_WR, GP9001_OBJECTBANK_SLOT, TIMEOUT
    );
endinterface

`default_nettype wire

// File: rtl/raizing_gp9001_bus.sv
// ============================================================================
// raizing_gp9001_bus : 68000 bus cycle -> single GP9001 operation initiator
// Rev 1.0
// ============================================================================
`default_nettype none

module raizing_gp9001_bus #(
    parameter int TIMEOUT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    raizing_gp9001_bus_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // op vector bit order: 0 SELECT_REG, 1 WRITE_REG, 2 WRITE_RAM, 3 READ_RAM_H,
    // 4 READ_RAM_L, 5 SET_RAM_PTR, 6 OBJECTBANK_WR
    state_t                 r_state;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic [6:0]             r_op;
    logic                   r_cs;
    logic                   r_rnw;
    logic [15:0]            r_din;
    logic [15:0]            r_dout;
    logic                   r_dtack_n;
    logic [2:0]             r_slot;
    logic                   r_timeout;

    logic                   w_sel;
    logic [6:0]             w_op;
    logic [15:0]            w_local_val;

    assign w_sel = bus.CPU_CS | bus.CPU_OBJ_CS;

    always_comb begin
        w_op        = 7'd0;
        w_local_val = 16'hFFFF;
        if (bus.CPU_CS) begin
            case (bus.CPU_ADDR)
                3'd0:    if (!bus.CPU_RNW) w_op[5] = 1'b1;
                3'd2:    if (bus.CPU_RNW) w_op[3] = 1'b1; else w_op[2] = 1'b1;
                3'd3:    if (bus.CPU_RNW) w_op[4] = 1'b1; else w_op[2] = 1'b1;
                3'd4:    if (!bus.CPU_RNW) w_op[0] = 1'b1;
                3'd6: begin
                    if (bus.CPU_RNW)
                        w_local_val = {13'd0, bus.CPU_HSYNC, bus.CPU_VSYNC, bus.CPU_FBLANK};
                    else
                        w_op[1] = 1'b1;
                end
                default: w_op = 7'd0;
            endcase
        end else if (bus.CPU_OBJ_CS && !bus.CPU_RNW) begin
            w_op[6] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= 7'd0;
            r_cs      <= 1'b0;
            r_rnw     <= 1'b0;
            r_din     <= 16'd0;
            r_dout    <= 16'd0;
            r_dtack_n <= 1'b1;
            r_slot    <= 3'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel) begin
                        if (w_op != 7'd0) begin
                            r_op    <= w_op;
                            r_cs    <= 1'b1;
                            r_rnw   <= bus.CPU_RNW;
                            r_din   <= bus.CPU_DIN;
                            r_cnt   <= '0;
                            if (w_op[6])
                                r_slot <= bus.CPU_ADDR;
                            r_state <= S_WAIT;
                        end else begin
                            r_dout    <= w_local_val;
                            r_dtack_n <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    // An abandoned CPU cycle still finishes its GP9001 op, but without DTACK
                    if (bus.GP9001ACK) begin
                        r_cs      <= 1'b0;
                        r_op      <= 7'd0;
                        if (r_rnw)
                            r_dout <= bus.GP9001DOUT;
                        r_dtack_n <= ~w_sel;
                        r_state   <= S_DONE;
                    end else if (r_cnt == {TIMEOUT_W{1'b1}}) begin
                        r_cs      <= 1'b0;
                        r_op      <= 7'd0;
                        r_dout    <= 16'hFFFF;
                        r_timeout <= 1'b1;
                        r_dtack_n <= ~w_sel;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!w_sel) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.CPU_DOUT                = r_dout;
    assign bus.CPU_DTACK_N             = r_dtack_n;
    assign bus.GP9001CS                = r_cs;
    assign bus.GP9001DIN               = r_din;
    assign bus.GP9001_OP_SELECT_REG    = r_op[0];
    assign bus.GP9001_OP_WRITE_REG     = r_op[1];
    assign bus.GP9001_OP_WRITE_RAM     = r_op[2];
    assign bus.GP9001_OP_READ_RAM_H    = r_op[3];
    assign bus.GP9001_OP_READ_RAM_L    = r_op[4];
    assign bus.GP9001_OP_SET_RAM_PTR   = r_op[5];
    assign bus.GP9001_OP_OBJECTBANK_WR = r_op[6];
    assign bus.GP9001_OBJECTBANK_SLOT  = r_slot;
    assign bus.TIMEOUT                 = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_raizing_gp9001_bus.sv
// ============================================================================
// tb_raizing_gp9001_bus : transaction-level model checked against the DUT
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_raizing_gp9001_bus;
    localparam int TW = 8;

    logic CLK;
    logic RESET_N;
    raizing_gp9001_bus_if bus ();

    raizing_gp9001_bus #(.TIMEOUT_W(TW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // Expected outputs; op bits: 0 SEL_REG,1 WR_REG,2 WR_RAM,3 RD_H,4 RD_L,5 SET_PTR,6 OBJ_WR
    logic        exp_cs, exp_dtack_n, exp_timeout;
    logic [6:0]  exp_op;
    logic [15:0] exp_din, exp_dout;
    logic [2:0]  exp_slot;

    logic [6:0] act_op;
    assign act_op = {bus.GP9001_OP_OBJECTBANK_WR, bus.GP9001_OP_SET_RAM_PTR,
                     bus.GP9001_OP_READ_RAM_L, bus.GP9001_OP_READ_RAM_H,
                     bus.GP9001_OP_WRITE_RAM, bus.GP9001_OP_WRITE_REG,
                     bus.GP9001_OP_SELECT_REG};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("gp_cs",   {15'd0, bus.GP9001CS},    {15'd0, exp_cs});
            chk("ops",     {9'd0, act_op},           {9'd0, exp_op});
            chk("gp_din",  bus.GP9001DIN,            exp_din);
            chk("cpu_dout", bus.CPU_DOUT,            exp_dout);
            chk("dtack_n", {15'd0, bus.CPU_DTACK_N}, {15'd0, exp_dtack_n});
            chk("slot",    {13'd0, bus.GP9001_OBJECTBANK_SLOT}, {13'd0, exp_slot});
            chk("timeout", {15'd0, bus.TIMEOUT},     {15'd0, exp_timeout});
        end
    end

    task automatic set_reset_exp();
        exp_cs = 0; exp_op = 0; exp_din = 0; exp_dout = 0;
        exp_dtack_n = 1; exp_timeout = 0; exp_slot = 0;
    endtask

    // Address-map decode: which op (if any) and what a local access returns
    function automatic void decode(input logic cs, input logic obj, input logic [2:0] a,
                                   input logic rnw, input logic hs, input logic vs,
                                   input logic fb, output logic [6:0] op,
                                   output logic [15:0] lv);
        op = 7'd0;
        lv = 16'hFFFF;
        if (cs) begin
            if (a == 3'd0 && !rnw)                op = 7'b0100000;
            else if ((a == 3'd2 || a == 3'd3) && !rnw) op = 7'b0000100;
            else if (a == 3'd2 && rnw)            op = 7'b0001000;
            else if (a == 3'd3 && rnw)            op = 7'b0010000;
            else if (a == 3'd4 && !rnw)           op = 7'b0000001;
            else if (a == 3'd6 && !rnw)           op = 7'b0000010;
            else if (a == 3'd6 && rnw)            lv = {13'd0, hs, vs, fb};
        end else if (obj && !rnw) begin
            op = 7'b1000000;
        end
    endfunction

    // nwait: WAIT cycle (1-based) in which ACK is pulsed, 0 = never.
    // drop_at: WAIT cycle in which the CPU abandons the cycle, 0 = never.
    task automatic run_cycle(input logic cs, input logic obj, input logic [2:0] a,
                             input logic rnw, input logic [15:0] din, input int nwait,
                             input logic [15:0] gdata, input logic hs, input logic vs,
                             input logic fb, input int drop_at);
        logic [6:0]  op;
        logic [15:0] lv;
        logic        sel_on;
        bit          acked;
        decode(cs, obj, a, rnw, hs, vs, fb, op, lv);
        @(posedge CLK); #1;
        bus.CPU_CS = cs; bus.CPU_OBJ_CS = obj; bus.CPU_ADDR = a; bus.CPU_RNW = rnw;
        bus.CPU_DIN = din; bus.CPU_HSYNC = hs; bus.CPU_VSYNC = vs; bus.CPU_FBLANK = fb;
        sel_on = 1'b1;
        @(posedge CLK); #1;
        if (op != 7'd0) begin
            exp_cs = 1; exp_op = op; exp_din = din;
            if (op[6]) exp_slot = a;
            for (int i = 1; i <= (1 << TW); i++) begin
                if (i == nwait) begin
                    bus.GP9001ACK = 1'b1; bus.GP9001DOUT = gdata;
                end
                if (i == drop_at) begin
                    bus.CPU_CS = 1'b0; bus.CPU_OBJ_CS = 1'b0; sel_on = 1'b0;
                end
                @(posedge CLK); #1;
                acked = (i == nwait);
                bus.GP9001ACK = 1'b0; bus.GP9001DOUT = 16'h0000;
                if (acked || i == (1 << TW)) begin
                    exp_cs = 0; exp_op = 0;
                    exp_dtack_n = ~sel_on;
                    if (!acked) begin
                        exp_dout = 16'hFFFF; exp_timeout = 1;
                    end else if (rnw) begin
                        exp_dout = gdata;
                    end
                    break;
                end
            end
        end else begin
            exp_dtack_n = 0; exp_dout = lv;
            bus.CPU_HSYNC = ~hs; bus.CPU_VSYNC = ~vs; bus.CPU_FBLANK = ~fb;
        end
        @(posedge CLK); #1;
        bus.CPU_CS = 1'b0; bus.CPU_OBJ_CS = 1'b0;
        @(posedge CLK); #1;
        exp_dtack_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N = 1'b0;
        bus.CPU_CS = 0; bus.CPU_OBJ_CS = 0; bus.CPU_ADDR = 0; bus.CPU_RNW = 0;
        bus.CPU_DIN = 0; bus.GP9001ACK = 0; bus.GP9001DOUT = 0;
        bus.CPU_HSYNC = 0; bus.CPU_VSYNC = 0; bus.CPU_FBLANK = 0;
        set_reset_exp();
        @(posedge CLK); #1;
        chk_en = 1'b1;
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // cs obj addr rnw din nwait gdata hs vs fb drop
        run_cycle(1, 0, 3'd0, 0, 16'h1234, 3, 16'h0000, 0, 0, 0, 0);
        run_cycle(1, 0, 3'd3, 1, 16'h0000, 1, 16'hBEEF, 0, 0, 0, 0);
        chk("lit_beef", bus.CPU_DOUT, 16'hBEEF);
        run_cycle(0, 1, 3'd5, 0, 16'h0007, 2, 16'h0000, 0, 0, 0, 0);
        chk("lit_slot", {13'd0, bus.GP9001_OBJECTBANK_SLOT}, 16'd5);
        chk("lit_objdin", bus.GP9001DIN, 16'h0007);
        run_cycle(1, 0, 3'd6, 1, 16'h0000, 0, 16'h0000, 1, 0, 1, 0);
        chk("lit_status", bus.CPU_DOUT, 16'h0005);
        run_cycle(1, 0, 3'd2, 1, 16'h0000, 2, 16'h5A5A, 0, 0, 0, 0);
        run_cycle(1, 0, 3'd2, 0, 16'hC0DE, 1, 16'h0000, 0, 0, 0, 0);
        run_cycle(1, 0, 3'd4, 0, 16'h0011, 4, 16'h0000, 0, 0, 0, 0);
        run_cycle(1, 0, 3'd6, 0, 16'h8001, 1, 16'h0000, 0, 0, 0, 0);
        run_cycle(1, 0, 3'd1, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0);
        chk("lit_local_rd", bus.CPU_DOUT, 16'hFFFF);
        run_cycle(1, 0, 3'd6, 1, 16'h0000, 0, 16'h0000, 0, 1, 0, 0);
        run_cycle(1, 0, 3'd7, 0, 16'h4444, 0, 16'h0000, 0, 0, 0, 0);
        run_cycle(0, 1, 3'd2, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
        run_cycle(1, 1, 3'd4, 0, 16'h0099, 1, 16'h0000, 0, 0, 0, 0);
        run_cycle(1, 0, 3'd3, 1, 16'h0000, 3, 16'h7777, 0, 0, 0, 2);
        run_cycle(1, 0, 3'd2, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
        chk("lit_timeout", {15'd0, bus.TIMEOUT}, 16'd1);
        chk("lit_to_dout", bus.CPU_DOUT, 16'hFFFF);
        run_cycle(1, 0, 3'd0, 0, 16'h2468, 1, 16'h0000, 0, 0, 0, 0);
        chk("lit_to_sticky", {15'd0, bus.TIMEOUT}, 16'd1);

        // Reset in the middle of a WAIT, then a stale ACK
        @(posedge CLK); #1;
        bus.CPU_CS = 1; bus.CPU_ADDR = 3'd2; bus.CPU_RNW = 1; bus.CPU_DIN = 16'hAAAA;
        @(posedge CLK); #1;
        exp_cs = 1; exp_op = 7'b0001000; exp_din = 16'hAAAA;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET_N = 1'b0; bus.CPU_CS = 0;
        @(posedge CLK); #1;
        set_reset_exp();
        RESET_N = 1'b1;
        bus.GP9001ACK = 1'b1; bus.GP9001DOUT = 16'h1111;
        @(posedge CLK); #1;
        bus.GP9001ACK = 1'b0; bus.GP9001DOUT = 16'h0000;
        @(posedge CLK); #1;
        chk("lit_post_rst_dtack", {15'd0, bus.CPU_DTACK_N}, 16'd1);
        chk("lit_post_rst_dout", bus.CPU_DOUT, 16'h0000);
        run_cycle(1, 0, 3'd3, 1, 16'h0000, 2, 16'h3C3C, 0, 0, 0, 0);
        chk("lit_post_rst_rd", bus.CPU_DOUT, 16'h3C3C);

        @(posedge CLK); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
